// File: rtl/super_wb_arbiter_pkg.sv
// rtl/super_wb_arbiter_pkg.sv - shared types and defaults for the super writeback arbiter
//
// Purpose : priority-state encoding and default widths shared by the arbiter,
//           its grant FSM, its bus interface and the testbench.
// Ports   : none (package).
// Config  : SUPER_WB_STATS_EN is consumed by super_wb_arbiter, not here.

package super_wb_arbiter_pkg;

   typedef enum logic {
      PRI_REG   = 1'b0,
      PRI_SUPER = 1'b1
   } pri_state_t;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_MAX_WAIT = 4;
   localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/super_wb_arbiter_if.sv
// rtl/super_wb_arbiter_if.sv - request and register-file write bus for the super writeback arbiter
//
// Purpose : bundles both writeback request paths, the stall input and the
//           registered write-port controls.
// Signals : reg_valid/reg_dest/reg_data/reg_ready         regular path
//           super_valid/super_dest/super_data/super_ready regular-parallel super path
//           wb_stall                                      register file busy
//           wb_we/wb_addr/wb_data/super_sel               registered write port
// Modports: slave  - the arbiter
//           master - the writeback stage / register-file side driving requests

interface super_wb_arbiter_if
   import super_wb_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              reg_valid;
   logic [ADDR_W-1:0] reg_dest;
   logic [DATA_W-1:0] reg_data;
   logic              reg_ready;
   logic              super_valid;
   logic [ADDR_W-1:0] super_dest;
   logic [DATA_W-1:0] super_data;
   logic              super_ready;
   logic              wb_stall;
   logic              wb_we;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              super_sel;

   modport slave (
      input  reg_valid, reg_dest, reg_data, super_valid, super_dest, super_data, wb_stall,
      output reg_ready, super_ready, wb_we, wb_addr, wb_data, super_sel
   );

   modport master (
      output reg_valid, reg_dest, reg_data, super_valid, super_dest, super_data, wb_stall,
      input  reg_ready, super_ready, wb_we, wb_addr, wb_data, super_sel
   );
endinterface

// File: rtl/super_mux.sv
// rtl/super_mux.sv - SuperMux: two-way select between regular and super writeback payloads
//
// Purpose : combinational payload select, 1 = super path.
// Ports   : i_reg_data   regular payload
//           i_super_data super payload
//           i_super_sel  select super payload
//           o_data       selected payload

module super_mux #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_reg_data,
   input  logic [WIDTH-1:0] i_super_data,
   input  logic             i_super_sel,
   output logic [WIDTH-1:0] o_data
);
   assign o_data = i_super_sel ? i_super_data : i_reg_data;
endmodule

// File: rtl/super_wb_grant_fsm.sv
// rtl/super_wb_grant_fsm.sv - per-cycle grant decision with bounded super starvation
//
// Purpose : regular path wins conflicts until super has lost MAX_WAIT of them,
//           then super wins the next conflict.
// Ports   : i_clk, i_rst     clock, synchronous active-high reset
//           i_reg_valid      regular request pending
//           i_super_valid    super request pending
//           i_stall          register file cannot accept a write
//           o_reg_grant      regular request consumed this cycle
//           o_super_grant    super request consumed this cycle

module super_wb_grant_fsm
   import super_wb_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_reg_valid,
   input  logic i_super_valid,
   input  logic i_stall,
   output logic o_reg_grant,
   output logic o_super_grant
);
   localparam int              WCW   = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0]  MAX_C = WCW'(MAX_WAIT);

   pri_state_t     r_state;
   pri_state_t     w_state_nxt;
   logic [WCW-1:0] r_wait_cnt;
   logic [WCW-1:0] w_wait_nxt;
   logic           w_open;
   logic           w_both;

   always_comb begin
      w_open        = !i_stall && !i_rst;   // nothing is consumed while resetting
      w_both        = i_reg_valid && i_super_valid;
      o_reg_grant   = 1'b0;
      o_super_grant = 1'b0;
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;

      if (w_open) begin
         if (w_both) begin
            if (r_state == PRI_SUPER) o_super_grant = 1'b1;
            else                      o_reg_grant   = 1'b1;
         end else begin
            o_reg_grant   = i_reg_valid;
            o_super_grant = i_super_valid;
         end
      end

      if (o_super_grant) begin
         w_state_nxt = PRI_REG;
         w_wait_nxt  = '0;
      end else if (o_reg_grant && w_both && r_state == PRI_REG) begin
         if (r_wait_cnt != MAX_C) w_wait_nxt = r_wait_cnt + 1'b1;
         if (w_wait_nxt == MAX_C) w_state_nxt = PRI_SUPER;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= PRI_REG;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end
endmodule

// File: rtl/super_wb_arbiter.sv
// rtl/super_wb_arbiter.sv - shares the register-file write port between regular and super writeback
//
// Purpose : arbitrates the two writeback paths every cycle, selects the winner
//           through SuperMux and registers the write-port controls (latency 1).
//           Writes to r0 are consumed but never enabled.
// Ports   : i_clk, i_rst  clock, synchronous active-high reset
//           i_bus         super_wb_arbiter_if.slave (requests, readies, write port)
//           o_stat_*      (SUPER_WB_STATS_EN only) saturating counters of regular
//                         grants, super grants, both-valid cycles, forced super grants
// Config  : SUPER_WB_STATS_EN adds the statistics counters and ports.

module super_wb_arbiter
   import super_wb_arbiter_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
`ifdef SUPER_WB_STATS_EN
   ,
   parameter int CNT_W    = DEF_CNT_W
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   super_wb_arbiter_if.slave  i_bus
`ifdef SUPER_WB_STATS_EN
   ,
   output logic [CNT_W-1:0]   o_stat_reg_wr,
   output logic [CNT_W-1:0]   o_stat_super_wr,
   output logic [CNT_W-1:0]   o_stat_conflict,
   output logic [CNT_W-1:0]   o_stat_forced
`endif
);
   localparam int PW = ADDR_W + DATA_W;

   logic              w_reg_grant;
   logic              w_super_grant;
   logic              w_grant;
   logic [PW-1:0]     w_mux_out;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_sel;

   super_wb_grant_fsm #(.MAX_WAIT(MAX_WAIT)) u_grant_fsm (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_reg_valid   (i_bus.reg_valid),
      .i_super_valid (i_bus.super_valid),
      .i_stall       (i_bus.wb_stall),
      .o_reg_grant   (w_reg_grant),
      .o_super_grant (w_super_grant)
   );

   // Address travels with data through the same mux so both follow the winner.
   super_mux #(.WIDTH(PW)) u_super_mux (
      .i_reg_data   ({i_bus.reg_dest, i_bus.reg_data}),
      .i_super_data ({i_bus.super_dest, i_bus.super_data}),
      .i_super_sel  (w_super_grant),
      .o_data       (w_mux_out)
   );

   assign w_grant           = w_reg_grant || w_super_grant;
   assign i_bus.reg_ready   = w_reg_grant;
   assign i_bus.super_ready = w_super_grant;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_sel  <= 1'b0;
      end else begin
         // r0 is hard-wired: the write is consumed but never enabled.
         r_we <= w_grant && (w_mux_out[PW-1:DATA_W] != '0);
         if (w_grant) begin
            r_addr <= w_mux_out[PW-1:DATA_W];
            r_data <= w_mux_out[DATA_W-1:0];
            r_sel  <= w_super_grant;
         end
      end
   end

   assign i_bus.wb_we     = r_we;
   assign i_bus.wb_addr   = r_addr;
   assign i_bus.wb_data   = r_data;
   assign i_bus.super_sel = r_sel;

`ifdef SUPER_WB_STATS_EN
   logic [CNT_W-1:0] r_stat_reg;
   logic [CNT_W-1:0] r_stat_super;
   logic [CNT_W-1:0] r_stat_conf;
   logic [CNT_W-1:0] r_stat_forced;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stat_reg    <= '0;
         r_stat_super  <= '0;
         r_stat_conf   <= '0;
         r_stat_forced <= '0;
      end else begin
         if (w_reg_grant && r_stat_reg != '1)
            r_stat_reg <= r_stat_reg + 1'b1;
         if (w_super_grant && r_stat_super != '1)
            r_stat_super <= r_stat_super + 1'b1;
         if (i_bus.reg_valid && i_bus.super_valid && r_stat_conf != '1)
            r_stat_conf <= r_stat_conf + 1'b1;
         // Super only beats a pending regular write when priority was forced.
         if (w_super_grant && i_bus.reg_valid && r_stat_forced != '1)
            r_stat_forced <= r_stat_forced + 1'b1;
      end
   end

   assign o_stat_reg_wr   = r_stat_reg;
   assign o_stat_super_wr = r_stat_super;
   assign o_stat_conflict = r_stat_conf;
   assign o_stat_forced   = r_stat_forced;
`endif
endmodule
